// File: rtl/arc4_pkg.sv
// Shared ARC4 types and constants, used by both the encrypt and decrypt paths.
package arc4_pkg;

    localparam int unsigned S_SIZE = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        StIdle,
        StLenRd,
        StLenLat,
        StSI,
        StSJ,
        StSwapJ,
        StSwapI,
        StPad,
        StXor
    } state_e;

endpackage

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: runs the PRGA over a pre-scheduled S memory and writes
// the length-prefixed ciphertext, six cycles per payload byte.
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic [7:0] ct_addr,
    output logic [7:0] ct_wrdata,
    output logic       ct_wren
);

    state_e state_q;
    byte_t  j_q;
    byte_t  k_q;
    byte_t  len_q;
    byte_t  si_q;
    byte_t  sj_q;
    byte_t  ptb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            ptb_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        j_q     <= '0;
                        state_q <= StLenRd;
                    end
                end
                StLenRd: state_q <= StLenLat;
                StLenLat: begin
                    len_q   <= pt_rddata;
                    k_q     <= 8'd1;
                    state_q <= (pt_rddata == 8'd0) ? StIdle : StSI;
                end
                StSI: state_q <= StSJ;
                StSJ: begin
                    si_q    <= s_rddata;
                    ptb_q   <= pt_rddata;
                    j_q     <= j_q + s_rddata;
                    state_q <= StSwapJ;
                end
                StSwapJ: begin
                    sj_q    <= s_rddata;
                    state_q <= StSwapI;
                end
                StSwapI: state_q <= StPad;
                StPad:   state_q <= StXor;
                StXor: begin
                    if (k_q == len_q) begin
                        state_q <= StIdle;
                    end else begin
                        k_q     <= k_q + 8'd1;
                        state_q <= StSI;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory strobes follow the state; S_J and XOR forward read data the
    // same cycle it arrives, so these stay combinational.
    always_comb begin
        rdy       = (state_q == StIdle);
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;
        unique case (state_q)
            StLenLat: begin
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
            end
            StSI: begin
                s_addr  = k_q;
                pt_addr = k_q;
            end
            StSJ: s_addr = j_q + s_rddata;
            StSwapJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
            end
            StSwapI: begin
                s_addr   = k_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
            end
            StPad: s_addr = si_q + sj_q;
            StXor: begin
                ct_addr   = k_q;
                ct_wrdata = s_rddata ^ ptb_q;
                ct_wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt: behavioural S/pt/ct memories, a software
// ARC4 reference, and known-answer vectors.
module tb_arc4_encrypt;
    import arc4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] pt_addr, pt_rddata;
    logic [7:0] ct_addr, ct_wrdata;
    logic       ct_wren;

    byte_t smem   [S_SIZE];
    byte_t ptmem  [S_SIZE];
    byte_t ctmem  [S_SIZE];
    byte_t msm    [S_SIZE];
    byte_t exp_ct [S_SIZE];
    byte_t kv_ct  [10];
    byte_t kv_pt  [10];

    int n_checks = 0;
    int n_fail   = 0;
    int s_wr_cnt = 0;
    int ct_wr_cnt = 0;
    int s0, c0, lat, errs;

    arc4_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: read returns the pre-write contents.
    always @(posedge clk) begin
        s_rddata  <= smem[s_addr];
        pt_rddata <= ptmem[pt_addr];
        if (s_wren) begin
            smem[s_addr] = s_wrdata;
            s_wr_cnt     = s_wr_cnt + 1;
        end
        if (ct_wren) begin
            ctmem[ct_addr] = ct_wrdata;
            ct_wr_cnt      = ct_wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ksa(input byte_t k0, input byte_t k1, input byte_t k2);
        byte_t key [3];
        byte_t t;
        int    j;
        key[0] = k0;
        key[1] = k1;
        key[2] = k2;
        for (int i = 0; i < 256; i++) smem[i] = 8'(i);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(smem[i]) + int'(key[i % 3])) % 256;
            t       = smem[i];
            smem[i] = smem[j];
            smem[j] = t;
        end
    endtask

    // Textbook PRGA over a snapshot of S; leaves msm in its post-run state.
    task automatic ref_prga();
        int    j;
        int    len;
        byte_t t;
        for (int i = 0; i < 256; i++) msm[i] = smem[i];
        len = int'(ptmem[0]);
        exp_ct[0] = ptmem[0];
        j = 0;
        for (int i = 1; i <= len; i++) begin
            j = (j + int'(msm[i])) % 256;
            t      = msm[i];
            msm[i] = msm[j];
            msm[j] = t;
            exp_ct[i] = ptmem[i] ^ msm[(int'(msm[i]) + int'(msm[j])) % 256];
        end
    endtask

    task automatic load_plaintext();
        for (int i = 0; i < 10; i++) ptmem[i] = kv_pt[i];
    endtask

    task automatic run_msg(input bit busy_pulse, output int latency);
        int cyc;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) check("rdy_fall", {31'd0, rdy}, 32'd0);
            if (busy_pulse) en = (cyc >= 10 && cyc < 20);
        end while (!rdy && cyc < 3000);
        en      = 1'b0;
        latency = cyc + 1;
    endtask

    task automatic stress(input string tag);
        ptmem[0] = 8'd255;
        for (int i = 1; i < 256; i++) ptmem[i] = 8'($urandom_range(0, 255));
        ref_prga();
        s0 = s_wr_cnt;
        c0 = ct_wr_cnt;
        run_msg(1'b1, lat);
        check({tag, "_lat"}, lat, 32'd1533);
        check({tag, "_ct_wr"}, ct_wr_cnt - c0, 32'd256);
        check({tag, "_s_wr"}, s_wr_cnt - s0, 32'd510);
        errs = 0;
        for (int i = 0; i < 256; i++) if (ctmem[i] !== exp_ct[i]) errs++;
        check({tag, "_ct_errs"}, errs, 32'd0);
        errs = 0;
        for (int i = 0; i < 256; i++) if (smem[i] !== msm[i]) errs++;
        check({tag, "_s_final_errs"}, errs, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kv_pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        kv_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int i = 0; i < 256; i++) begin
            smem[i]  = 8'(i);
            ptmem[i] = 8'h00;
            ctmem[i] = 8'h00;
        end

        // Reset with en asserted throughout; it must not start a run.
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_wren", {30'd0, s_wren, ct_wren}, 32'd0);
        check("rst_addr", {8'd0, s_addr, pt_addr, ct_addr}, 32'd0);
        check("rst_wdata", {16'd0, s_wrdata, ct_wrdata}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_idle_rdy", {31'd0, rdy}, 32'd1);
        check("rst_no_writes", s_wr_cnt + ct_wr_cnt, 32'd0);

        // Empty message.
        ptmem[0] = 8'h00;
        ctmem[0] = 8'hFF;
        s0 = s_wr_cnt;
        c0 = ct_wr_cnt;
        run_msg(1'b0, lat);
        check("empty_lat", lat, 32'd3);
        check("empty_ct0", {24'd0, ctmem[0]}, 32'd0);
        check("empty_s_wr", s_wr_cnt - s0, 32'd0);
        check("empty_ct_wr", ct_wr_cnt - c0, 32'd1);

        // Known vector: key "Key", plaintext "Plaintext".
        ksa(8'h4B, 8'h65, 8'h79);
        load_plaintext();
        c0 = ct_wr_cnt;
        run_msg(1'b0, lat);
        check("kv_lat", lat, 32'd57);
        check("kv_ct_wr", ct_wr_cnt - c0, 32'd10);
        for (int i = 0; i < 10; i++) check($sformatf("kv_ct%0d", i), {24'd0, ctmem[i]},
                                           {24'd0, kv_ct[i]});

        // Round trip: ciphertext back in as plaintext under the same schedule.
        for (int i = 0; i < 10; i++) ptmem[i] = ctmem[i];
        for (int i = 0; i < 10; i++) ctmem[i] = 8'h00;
        ksa(8'h4B, 8'h65, 8'h79);
        run_msg(1'b0, lat);
        for (int i = 0; i < 10; i++) check($sformatf("rt_pt%0d", i), {24'd0, ctmem[i]},
                                           {24'd0, kv_pt[i]});

        // Reset while byte 4 is in its swap; the abort must write nothing more.
        ksa(8'h4B, 8'h65, 8'h79);
        load_plaintext();
        for (int i = 0; i < 10; i++) ctmem[i] = 8'h00;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (22) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_rdy", {31'd0, rdy}, 32'd1);
        s0 = s_wr_cnt;
        c0 = ct_wr_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_s_wr", s_wr_cnt - s0, 32'd0);
        check("abort_no_ct_wr", ct_wr_cnt - c0, 32'd0);
        check("abort_partial_ct3", {24'd0, ctmem[3]}, {24'd0, kv_ct[3]});
        check("abort_partial_ct4", {24'd0, ctmem[4]}, 32'd0);
        ksa(8'h4B, 8'h65, 8'h79);
        load_plaintext();
        run_msg(1'b0, lat);
        check("rerun_lat", lat, 32'd57);
        errs = 0;
        for (int i = 0; i < 10; i++) if (ctmem[i] !== kv_ct[i]) errs++;
        check("rerun_ct_errs", errs, 32'd0);

        // Identity S, full length; bytes 1 and 2 use pads 02 and 05.
        for (int i = 0; i < 256; i++) smem[i] = 8'(i);
        stress("stress_id");
        check("id_ct1", {24'd0, ctmem[1]}, {24'd0, ptmem[1] ^ 8'h02});
        check("id_ct2", {24'd0, ctmem[2]}, {24'd0, ptmem[2] ^ 8'h05});

        // Random schedule, full length.
        ksa(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)));
        stress("stress_rnd");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
